// File: rtl/crc_stream_engine_pkg.sv
// Shared types and the single-bit CRC division step used by the
// streaming CRC engine and the legacy one-shot generator/verifier.
package crc_stream_engine_pkg;

    localparam int CRC_MAX_W = 64;

    typedef enum logic {
        CRC_GEN = 1'b0,
        CRC_VER = 1'b1
    } crc_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACCEPT,
        FINISH
    } crc_state_e;

    // One MSB-first division step on a w-bit register held in the low bits.
    function automatic logic [CRC_MAX_W-1:0] crc_bitstep(
        input logic [CRC_MAX_W-1:0] crc,
        input logic                 b,
        input logic [CRC_MAX_W-1:0] poly,
        input int unsigned          w
    );
        logic                 fb;
        logic [CRC_MAX_W-1:0] nxt;
        logic [CRC_MAX_W-1:0] mask;
        fb   = (|(crc & (CRC_MAX_W'(1) << (w - 1)))) ^ b;
        nxt  = (crc << 1) ^ (fb ? poly : '0);
        mask = (CRC_MAX_W'(1) << w) - CRC_MAX_W'(1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// Combinational chain of N CRC division steps, consuming the given
// bits MSB first.
module crc_stream_engine_step
    import crc_stream_engine_pkg::*;
#(
    parameter int                   CRC_WIDTH = 8,
    parameter int                   N         = 1,
    parameter logic [CRC_WIDTH-1:0] POLY_LO   = 'h07
) (
    input  logic [CRC_WIDTH-1:0] i_crc,
    input  logic [N-1:0]         i_bits,
    output logic [CRC_WIDTH-1:0] o_crc
);

    logic [CRC_WIDTH-1:0] w_acc;

    always_comb begin
        w_acc = i_crc;
        for (int i = N - 1; i >= 0; i--) begin
            w_acc = CRC_WIDTH'(crc_bitstep(CRC_MAX_W'(w_acc), i_bits[i],
                                           CRC_MAX_W'(POLY_LO), CRC_WIDTH));
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generate/verify engine: words arrive over valid/ready and
// are divided MSB first, XOR_OPS_PER_CYCLE bits per clock.
module crc_stream_engine
    import crc_stream_engine_pkg::*;
#(
    parameter int                   DATA_W            = 8,
    parameter int                   CRC_WIDTH         = 8,
    parameter logic [CRC_WIDTH:0]   POLY              = 9'h107,
    parameter logic [CRC_WIDTH-1:0] SEED              = '0,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT           = '0,
    parameter int                   XOR_OPS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_last,
    output logic [CRC_WIDTH-1:0] crc_out,
    output logic                 crc_valid,
    output logic                 done,
    output logic                 busy
);

    localparam int OPS   = XOR_OPS_PER_CYCLE;
    localparam int STEPS = DATA_W / OPS;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CRC_WIDTH-1:0] POLY_LO = POLY[CRC_WIDTH-1:0];

    crc_state_e           r_state;
    crc_mode_e            r_mode;
    logic [DATA_W-1:0]    r_shift;
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_last;

    logic                 w_xfer;
    logic [CRC_WIDTH-1:0] w_crc_nxt;

    assign w_xfer = in_valid && in_ready;

    crc_stream_engine_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .N         (OPS),
        .POLY_LO   (POLY_LO)
    ) u_step (
        .i_crc  (r_crc),
        .i_bits (r_shift[DATA_W-1 -: OPS]),
        .o_crc  (w_crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= CRC_GEN;
            r_shift   <= '0;
            r_crc     <= SEED;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            crc_out   <= '0;
            crc_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_mode   <= crc_mode_e'(mode_i);
                        r_shift  <= in_data;
                        r_crc    <= SEED;
                        r_cnt    <= CNT_W'(STEPS);
                        r_last   <= in_last;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_crc   <= w_crc_nxt;
                    r_shift <= r_shift << OPS;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_last) begin
                            r_state <= FINISH;
                        end else begin
                            r_state  <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACCEPT: begin
                    // crc_reg carries across words; only the shifter reloads
                    if (w_xfer) begin
                        r_shift  <= in_data;
                        r_cnt    <= CNT_W'(STEPS);
                        r_last   <= in_last;
                        in_ready <= 1'b0;
                        r_state  <= SHIFT;
                    end
                end
                FINISH: begin
                    crc_out   <= (r_mode == CRC_GEN) ? (r_crc ^ XOR_OUT)
                                                     : r_crc;
                    crc_valid <= (r_mode == CRC_VER) && (r_crc == '0);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: an 8-bit bit-serial instance and
// a 56-bit, 8-steps-per-clock instance sharing clock and reset.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_mode, a_valid, a_ready, a_last, a_cv, a_done, a_busy;
    logic [7:0]  a_data, a_crc;
    logic        b_mode, b_valid, b_ready, b_last, b_cv, b_done, b_busy;
    logic [55:0] b_data;
    logic [7:0]  b_crc;

    crc_stream_engine #(
        .DATA_W (8), .CRC_WIDTH (8), .POLY (9'h107),
        .SEED (8'h00), .XOR_OUT (8'h00), .XOR_OPS_PER_CYCLE (1)
    ) u_a (
        .clk (clk), .rst_n (rst_n), .mode_i (a_mode),
        .in_valid (a_valid), .in_ready (a_ready), .in_data (a_data),
        .in_last (a_last), .crc_out (a_crc), .crc_valid (a_cv),
        .done (a_done), .busy (a_busy)
    );

    crc_stream_engine #(
        .DATA_W (56), .CRC_WIDTH (8), .POLY (9'h107),
        .SEED (8'h00), .XOR_OUT (8'h00), .XOR_OPS_PER_CYCLE (8)
    ) u_b (
        .clk (clk), .rst_n (rst_n), .mode_i (b_mode),
        .in_valid (b_valid), .in_ready (b_ready), .in_data (b_data),
        .in_last (b_last), .crc_out (b_crc), .crc_valid (b_cv),
        .done (b_done), .busy (b_busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] a_qc[$];
    logic       a_qv[$];
    int         a_qt[$];
    logic [7:0] b_qc[$];
    logic       b_qv[$];
    int         b_qt[$];

    always @(negedge clk) begin
        if (a_done) begin
            a_qc.push_back(a_crc);
            a_qv.push_back(a_cv);
            a_qt.push_back(cyc);
        end
        if (b_done) begin
            b_qc.push_back(b_crc);
            b_qv.push_back(b_cv);
            b_qt.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int u);
        return (u == 0) ? a_ready : b_ready;
    endfunction

    task automatic set_in(input int u, input logic v, input logic [63:0] d,
                          input logic last, input logic mode);
        if (u == 0) begin
            a_valid = v; a_data = d[7:0]; a_last = last; a_mode = mode;
        end else begin
            b_valid = v; b_data = d[55:0]; b_last = last; b_mode = mode;
        end
    endtask

    task automatic drop_valid(input int u);
        if (u == 0) a_valid = 1'b0;
        else        b_valid = 1'b0;
    endtask

    task automatic send(input int u, input logic [63:0] d, input logic last,
                        input logic mode, input int gap, output int acc);
        int k;
        @(negedge clk);
        set_in(u, 1'b1, d, last, mode);
        k = 0;
        while (!rdy(u) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("accept_u%0d", u), 64'(rdy(u)), 64'd1);
        @(posedge clk);
        #1 acc = cyc;
        if (gap > 0) begin
            @(negedge clk);
            drop_valid(u);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? a_qc.size() : b_qc.size();
    endfunction

    task automatic clr(input int u);
        if (u == 0) begin a_qc.delete(); a_qv.delete(); a_qt.delete(); end
        else        begin b_qc.delete(); b_qv.delete(); b_qt.delete(); end
    endtask

    task automatic wait_done(input int u, input int n);
        int k;
        k = 0;
        while (qsize(u) < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic frame(input int u, input logic [63:0] w[$],
                         input logic mode, input int gap,
                         input logic [7:0] ec, input logic ecv,
                         input int elat, input string tag);
        int acc, t0;
        clr(u);
        t0 = 0;
        for (int i = 0; i < w.size(); i++) begin
            send(u, w[i], (i == w.size() - 1), mode, gap, acc);
            if (i == 0) t0 = acc;
        end
        drop_valid(u);
        wait_done(u, 1);
        chk({tag, "_done"}, 64'(qsize(u)), 64'd1);
        if (qsize(u) > 0) begin
            chk({tag, "_crc"}, (u == 0) ? 64'(a_qc[0]) : 64'(b_qc[0]), 64'(ec));
            chk({tag, "_cv"}, (u == 0) ? 64'(a_qv[0]) : 64'(b_qv[0]), 64'(ecv));
            if (elat > 0)
                chk({tag, "_lat"},
                    64'(((u == 0) ? a_qt[0] : b_qt[0]) - t0), 64'(elat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] q[$];
        int acc;
        rst_n = 1'b0;
        set_in(0, 1'b0, 64'd0, 1'b0, 1'b0);
        set_in(1, 1'b0, 64'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_crc", 64'(a_crc), 64'd0);
        chk("rst_cv", 64'(a_cv), 64'd0);
        rst_n = 1'b1;

        q = '{64'h31, 64'h32, 64'h33, 64'h34, 64'h35,
              64'h36, 64'h37, 64'h38, 64'h39};
        frame(0, q, 1'b0, 0, 8'hF4, 1'b0, 0, "gen_check");
        q = '{64'hFF};
        frame(0, q, 1'b0, 0, 8'hF3, 1'b0, 9, "gen_ff");
        q = '{64'h01};
        frame(0, q, 1'b0, 0, 8'h07, 1'b0, 9, "gen_01");

        q = '{64'h31, 64'h32, 64'h33, 64'h34, 64'h35,
              64'h36, 64'h37, 64'h38, 64'h39, 64'hF4};
        frame(0, q, 1'b1, 0, 8'h00, 1'b1, 0, "ver_ok");
        q[9] = 64'hF5;
        frame(0, q, 1'b1, 0, 8'h07, 1'b0, 0, "ver_bad");

        q = '{64'h01};
        frame(1, q, 1'b0, 0, 8'h07, 1'b0, 8, "w56_gen1");
        q = '{64'h100};
        frame(1, q, 1'b0, 0, 8'h15, 1'b0, 0, "w56_gen2");
        q = '{64'h80000000000000};
        frame(1, q, 1'b0, 0, 8'h8A, 1'b0, 0, "w56_gen3");
        for (int g = 0; g <= 2; g += 2) begin
            q = '{64'h0, 64'h00000000000107};
            frame(1, q, 1'b1, g, 8'h00, 1'b1, 0, $sformatf("w56_ver1_g%0d", g));
            q = '{64'h0, 64'h00000000010015};
            frame(1, q, 1'b1, g, 8'h00, 1'b1, 0, $sformatf("w56_ver2_g%0d", g));
            q = '{64'h80, 64'h8A};
            frame(1, q, 1'b1, g, 8'h00, 1'b1, 0, $sformatf("w56_ver3_g%0d", g));
        end
        q = '{64'h0, 64'h100};
        frame(1, q, 1'b0, 2, 8'h15, 1'b0, 0, "w56_gen2_gap");

        clr(0);
        send(0, 64'hFF, 1'b1, 1'b0, 0, acc);
        drop_valid(0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready", 64'(a_ready), 64'd1);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        repeat (15) @(negedge clk);
        chk("midrst_nodone", 64'(qsize(0)), 64'd0);
        q = '{64'h01};
        frame(0, q, 1'b0, 0, 8'h07, 1'b0, 9, "after_rst");

        clr(0);
        send(0, 64'hFF, 1'b1, 1'b0, 0, acc);
        send(0, 64'hFF, 1'b0, 1'b1, 0, acc);
        send(0, 64'hF3, 1'b1, 1'b1, 0, acc);
        drop_valid(0);
        wait_done(0, 2);
        chk("b2b_count", 64'(qsize(0)), 64'd2);
        if (qsize(0) >= 2) begin
            chk("b2b_a_crc", 64'(a_qc[0]), 64'hF3);
            chk("b2b_a_cv", 64'(a_qv[0]), 64'd0);
            chk("b2b_b_crc", 64'(a_qc[1]), 64'h00);
            chk("b2b_b_cv", 64'(a_qv[1]), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
